// File: rtl/lpif_txrx_asym2_half_pack_ctrl.sv
// lpif_txrx_asym2_half_pack_ctrl
//
// Packs 145-bit LPIF beats into a 290-bit half-rate word for the TX FIFO.
// In two-beat mode (m_gen2_mode=0) the first beat fills the lower slot and the
// second the upper slot; in one-beat mode (m_gen2_mode=1) every beat forms a
// word on its own with the upper slot all-zero.
//
// Slot layout, LSB first:
//   [3:0] state, [5:4] protid, [133:6] data, [134] dvalid,
//   [142:135] crc, [143] crc_valid, [144] slot valid
//
// Ports:
//   lclk, rst_n         clock, asynchronous active-low reset
//   m_gen2_mode         1 = one beat per word, 0 = two beats per word
//   in_valid/in_ready   beat handshake
//   in_state .. in_crc_valid  beat fields
//   out_valid/out_ready word handshake toward the TX FIFO
//   out_data            packed word, lower slot in [144:0], upper in [289:145]
//   pack_busy           1 whenever a beat or word is held
//
// Build option:
//   LPIF_PACK_FLUSH_EN  when defined, a lone beat left in HALF for FLUSH_CYCLES
//                       idle cycles is pushed out with an all-zero upper slot.
//                       Undefined: HALF waits indefinitely for the second beat.
//
// state | meaning
// ------+----------------------------------------------------------
// EMPTY | no beat held, accepting the first beat of a word
// HALF  | lower slot held, waiting for the upper beat (or a flush)
// FULL  | word presented on out_data, waiting for out_ready

module lpif_txrx_asym2_half_pack_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic         lclk,
    input  logic         rst_n,
    input  logic         m_gen2_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_state,
    input  logic [1:0]   in_protid,
    input  logic [127:0] in_data,
    input  logic [0:0]   in_dvalid,
    input  logic [7:0]   in_crc,
    input  logic [0:0]   in_crc_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [289:0] out_data,
    output logic         pack_busy
);

    localparam int SLOT_W = 145;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in the range 1..15");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] lo_q, lo_d;
    logic [SLOT_W-1:0] hi_q, hi_d;
    logic              out_valid_q, out_valid_d;
    logic              pack_busy_q, pack_busy_d;

    logic [SLOT_W-1:0] beat_slot;
    logic              beat_acc;
    logic              word_xfer;

`ifdef LPIF_PACK_FLUSH_EN
    localparam logic [3:0] FLUSH_LIM = 4'(FLUSH_CYCLES);
    logic [3:0] flush_cnt_q, flush_cnt_d;
`endif

    assign beat_slot = {1'b1, in_crc_valid, in_crc, in_dvalid, in_data, in_protid, in_state};

    // A held word frees its slots only in the cycle it leaves, so in FULL the
    // beat side can only move when the word side does.
    assign in_ready  = (state_q == ST_FULL) ? out_ready : 1'b1;
    assign beat_acc  = in_valid & in_ready;
    assign word_xfer = (state_q == ST_FULL) & out_ready;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
`ifdef LPIF_PACK_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (beat_acc) begin
                    lo_d    = beat_slot;
                    hi_d    = '0;
                    state_d = m_gen2_mode ? ST_FULL : ST_HALF;
                end
            end
            ST_HALF: begin
                // m_gen2_mode is deliberately ignored here; a mode change only
                // applies from the first beat of the next word.
                if (beat_acc) begin
                    hi_d    = beat_slot;
                    state_d = ST_FULL;
                end
`ifdef LPIF_PACK_FLUSH_EN
                // A beat arriving in the terminal cycle wins over the flush.
                else if (flush_cnt_q == FLUSH_LIM) begin
                    hi_d    = '0;
                    state_d = ST_FULL;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
`endif
            end
            ST_FULL: begin
                if (word_xfer) begin
                    if (beat_acc) begin
                        lo_d    = beat_slot;
                        hi_d    = '0;
                        state_d = m_gen2_mode ? ST_FULL : ST_HALF;
                    end else begin
                        lo_d    = '0;
                        hi_d    = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                lo_d    = '0;
                hi_d    = '0;
                state_d = ST_EMPTY;
            end
        endcase
`ifdef LPIF_PACK_FLUSH_EN
        if (state_d != state_q) begin
            flush_cnt_d = '0;
        end
`endif
        out_valid_d = (state_d == ST_FULL);
        pack_busy_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            lo_q        <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            pack_busy_q <= 1'b0;
`ifdef LPIF_PACK_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            pack_busy_q <= pack_busy_d;
`ifdef LPIF_PACK_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign out_data  = {hi_q, lo_q};
    assign out_valid = out_valid_q;
    assign pack_busy = pack_busy_q;

endmodule

// File: tb/tb_lpif_txrx_asym2_half_pack_ctrl.sv
// Self-checking bench for lpif_txrx_asym2_half_pack_ctrl.
// Expected words are pushed to a scoreboard queue as beats complete them and
// compared against out_data while the DUT presents them.
`timescale 1ns/1ps
module tb_lpif_txrx_asym2_half_pack_ctrl;

    localparam int FLUSH   = 4;
    localparam int M_EMPTY = 0;
    localparam int M_HALF  = 1;
    localparam int M_FULL  = 2;

    logic         lclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_gen2_mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_state = '0;
    logic [1:0]   in_protid = '0;
    logic [127:0] in_data = '0;
    logic [0:0]   in_dvalid = '0;
    logic [7:0]   in_crc = '0;
    logic [0:0]   in_crc_valid = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [289:0] out_data;
    logic         pack_busy;

    always #5 lclk = ~lclk;

    lpif_txrx_asym2_half_pack_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .lclk         (lclk),
        .rst_n        (rst_n),
        .m_gen2_mode  (m_gen2_mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_state     (in_state),
        .in_protid    (in_protid),
        .in_data      (in_data),
        .in_dvalid    (in_dvalid),
        .in_crc       (in_crc),
        .in_crc_valid (in_crc_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .pack_busy    (pack_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [289:0] sb_q[$];
    logic [144:0] m_lo;
    int           m_state = M_EMPTY;
    int           words = 0;
`ifdef LPIF_PACK_FLUSH_EN
    int           m_cnt = 0;
`endif
    logic         cur_v, cur_mode, cur_ordy, cur_rdy;

    typedef struct {
        logic         v;
        logic         mode;
        logic         ordy;
        logic [3:0]   st;
        logic [127:0] d;
        logic         exp_rdy;
        logic         exp_ov;
        logic         exp_busy;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [289:0] act, input logic [289:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rand_beat();
        in_state     = 4'($urandom);
        in_protid    = 2'($urandom);
        in_data      = {$urandom, $urandom, $urandom, $urandom};
        in_dvalid    = 1'($urandom);
        in_crc       = 8'($urandom);
        in_crc_valid = 1'($urandom);
    endtask

    task automatic model_reset();
        m_state = M_EMPTY;
        sb_q.delete();
`ifdef LPIF_PACK_FLUSH_EN
        m_cnt = 0;
`endif
    endtask

    task automatic accept_first(input logic [144:0] s, input logic mode);
        if (mode) begin
            sb_q.push_back({145'd0, s});
            m_state = M_FULL;
        end else begin
            m_lo    = s;
            m_state = M_HALF;
        end
    endtask

    // Called at a falling edge: drive inputs, then check outputs against the model.
    task automatic step_drive(input logic v, input logic mode, input logic ordy);
        in_valid    = v;
        m_gen2_mode = mode;
        out_ready   = ordy;
        cur_v       = v;
        cur_mode    = mode;
        cur_ordy    = ordy;
        #1;
        cur_rdy = (m_state == M_FULL) ? ordy : 1'b1;
        chk("in_ready", in_ready, cur_rdy);
        chk("out_valid", out_valid, m_state == M_FULL);
        chk("pack_busy", pack_busy, m_state != M_EMPTY);
        if (m_state == M_FULL) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got word %h required none", out_data);
            end else begin
                chk("out_data", out_data, sb_q[0]);
            end
        end
    endtask

    // Advance the model across the rising edge, then wait for the next falling edge.
    task automatic step_commit();
        logic [144:0] s;
        logic         acc;
        s   = {1'b1, in_crc_valid, in_crc, in_dvalid, in_data, in_protid, in_state};
        acc = cur_v && cur_rdy;
        case (m_state)
            M_EMPTY: if (acc) accept_first(s, cur_mode);
            M_HALF: begin
                if (acc) begin
                    sb_q.push_back({s, m_lo});
                    m_state = M_FULL;
`ifdef LPIF_PACK_FLUSH_EN
                    m_cnt = 0;
                end else if (m_cnt == FLUSH) begin
                    sb_q.push_back({145'd0, m_lo});
                    m_state = M_FULL;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
`endif
                end
            end
            default: begin
                if (cur_ordy) begin
                    if (sb_q.size() > 0) sb_q.delete(0);
                    words++;
                    if (acc) accept_first(s, cur_mode);
                    else m_state = M_EMPTY;
                end
            end
        endcase
        @(negedge lclk);
    endtask

    task automatic step(input logic v, input logic mode, input logic ordy);
        step_drive(v, mode, ordy);
        step_commit();
    endtask

    logic [289:0] held;
    int           ov_cnt;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'h1, 128'hA000_0000_1111_2222_3333_4444_5555_00A1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'h2, 128'hB000_0000_6666_7777_8888_9999_AAAA_00B2, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'h0, 128'h0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'h3, 128'hC000_0000_0000_0000_0000_0000_0000_00C3, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 128'h0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'h4, 128'hD000_0000_0000_0000_0000_0000_0000_00D4, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'h4, 128'hD000_0000_0000_0000_0000_0000_0000_00D4, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 128'h0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'h5, 128'hE000_0000_0000_0000_0000_0000_0000_00E5, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h6, 128'hF000_0000_0000_0000_0000_0000_0000_00F6, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 128'h0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'h0, 128'h0, 1'b1, 1'b0, 1'b0};

        // Reset values while rst_n is held low.
        repeat (3) @(negedge lclk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pack_busy", pack_busy, 1'b0);
        chk("rst_out_data", out_data, '0);
        @(negedge lclk);
        rst_n = 1'b1;
        model_reset();

        // Table-driven sequence: pairing, gen2 single-beat words, stalls,
        // mode change while HALF, simultaneous word/beat transfer.
        for (int i = 0; i < 12; i++) begin
            rand_beat();
            in_state = tbl[i].st;
            in_data  = tbl[i].d;
            step_drive(tbl[i].v, tbl[i].mode, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_pack_busy", i), pack_busy, tbl[i].exp_busy);
            if (i == 2) begin
                chk("pair_lo_data", out_data[6+:128], tbl[0].d);
                chk("pair_hi_data", out_data[151+:128], tbl[1].d);
                chk("pair_valid_bits", {out_data[289], out_data[144]}, 2'b11);
            end
            if (i == 4) begin
                chk("gen2_state", out_data[3:0], tbl[3].st);
                chk("gen2_upper_zero", out_data[289:145], '0);
            end
            step_commit();
        end

        // Backpressure: word held for 5 cycles with a beat pending.
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        rand_beat();
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            step_drive(1'b1, 1'b0, 1'b0);
            chk("stall_hold", out_data, held);
            step_commit();
        end
        step(1'b1, 1'b0, 1'b1);
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // 100 back-to-back beats in two-beat mode.
        words = 0;
        for (int k = 0; k < 100; k++) begin
            rand_beat();
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("b2b_words", words, 50);
        chk("b2b_drained", sb_q.size(), 0);

        // Lone beat followed by idle cycles.
        rand_beat(); step(1'b1, 1'b0, 1'b1);
`ifdef LPIF_PACK_FLUSH_EN
        for (int k = 1; k <= 6; k++) begin
            step_drive(1'b0, 1'b0, 1'b1);
            chk($sformatf("flush_ov_c%0d", k), out_valid, k == 6);
            if (k == 6) chk("flush_upper_zero", out_data[289:145], '0);
            step_commit();
        end
        step(1'b0, 1'b0, 1'b1);
`else
        ov_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step_drive(1'b0, 1'b0, 1'b1);
            if (out_valid) ov_cnt++;
            step_commit();
        end
        chk("noflush_ov_count", ov_cnt, 0);
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
`endif

        // Reset while HALF: held beat discarded, no partial word afterwards.
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_pack_busy", pack_busy, 1'b0);
        chk("midrst_out_data", out_data, '0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge lclk);
        rst_n = 1'b1;
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step_drive(1'b0, 1'b0, 1'b1);
            chk("postrst_out_valid", out_valid, 1'b0);
            step_commit();
        end
        rand_beat(); step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Random soak against the model.
        for (int k = 0; k < 300; k++) begin
            rand_beat();
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
        chk("final_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpif_txrx_asym2_half_pack_ctrl.md
LPIF_TXRX_ASYM2_HALF_PACK_CTRL -- requirements
Module: lpif_txrx_asym2_half_pack_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4, giving the idle cycles in HALF before a lone beat is flushed (range 1..15).
REQ-002 SHALL have port lclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-004 SHALL have port m_gen2_mode, input, 1 bit: 1 = one beat per output word, 0 = two beats per word.
REQ-005 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the beat handshake; a beat is accepted when both are 1.
REQ-006 SHALL have beat input ports in_state [3:0], in_protid [1:0], in_data [127:0], in_dvalid [0:0], in_crc [7:0] and in_crc_valid [0:0].
REQ-007 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: the word handshake toward the TX FIFO.
REQ-008 SHALL have port out_data, output, 290 bits: the packed half-rate word.
REQ-009 SHALL have port pack_busy, output, 1 bit: 1 when state is not EMPTY.

Function
REQ-010 SHALL pack each beat into a 145-bit slot, LSB first: state 4, protid 2, data 128, dvalid 1, crc 8, crc_valid 1, valid 1. The slot valid bit is 1 for a real beat.
REQ-011 SHALL place the lower slot at out_data[144:0] and the upper slot at out_data[289:145].
REQ-012 SHALL implement the states EMPTY, HALF and FULL.
REQ-013 In EMPTY, in_ready SHALL be 1. On an accepted beat, the beat SHALL go to the lower slot and the state SHALL move to HALF. If m_gen2_mode=1, the state SHALL move to FULL with the upper slot all-zero.
REQ-014 In HALF, in_ready SHALL be 1. On an accepted beat, the beat SHALL go to the upper slot and the state SHALL move to FULL.
REQ-015 In FULL, out_valid SHALL be 1 and out_data SHALL be stable until out_ready=1.
REQ-016 In FULL, in_ready SHALL equal out_ready. When word and beat transfer in the same cycle, the new beat SHALL become the next lower slot, and the state SHALL go to HALF, or to FULL if m_gen2_mode=1.
REQ-017 In FULL, a word transfer with no beat SHALL move the state to EMPTY and zero both slots.
REQ-018 Latency: the beat completing a word in cycle N SHALL produce out_valid=1 in cycle N+1. out_data SHALL be registered only, with no combinational path from in_* to out_*.
REQ-019 out_valid SHALL be 0 in EMPTY and HALF.
REQ-020 m_gen2_mode SHALL be sampled only on beat acceptance in EMPTY or FULL. A change while in HALF SHALL take effect from the next word.
REQ-021 Sustained throughput SHALL be one beat per cycle while out_ready=1.

Reset
REQ-022 While rst_n=0: state SHALL be EMPTY, out_data SHALL be all-zero, out_valid=0, pack_busy=0 and the flush counter 0.
REQ-023 in_ready SHALL be 1 during and after reset, because the state is EMPTY; the source SHALL hold in_valid=0 while rst_n=0.
REQ-024 Reset asserted mid-word SHALL discard any held beats, and no partial word SHALL be emitted after release.

Configuration
REQ-025 The macro LPIF_PACK_FLUSH_EN SHALL enable the HALF-state flush timer.
REQ-026 With LPIF_PACK_FLUSH_EN defined, a 4-bit counter SHALL:
- increment on each HALF cycle with no accepted beat;
- clear on any state change;
- on reaching FLUSH_CYCLES, move the state to FULL with the upper slot all-zero.
REQ-027 With LPIF_PACK_FLUSH_EN defined, a beat accepted in the same cycle the counter reaches FLUSH_CYCLES SHALL win: it fills the upper slot and no flush occurs.
REQ-028 Without LPIF_PACK_FLUSH_EN, the counter SHALL not exist and HALF SHALL wait indefinitely for the second beat.

Verification
REQ-029 m_gen2_mode=0, out_ready=1, beats with in_data=A then B on consecutive cycles -> next cycle out_valid=1, out_data[6+:128]=A, out_data[151+:128]=B, bits 144 and 289 both 1.
REQ-030 m_gen2_mode=1, one beat with in_state=4'h3 -> next cycle out_valid=1, out_data[3:0]=3, out_data[289:145]=0.
REQ-031 out_ready=0 while FULL for 5 cycles, in_valid=1 -> in_ready=0, out_data unchanged for all 5 cycles; out_ready=1 -> word transfers and the pending beat is accepted as the new lower slot in that cycle.
REQ-032 100 back-to-back beats, out_ready=1, m_gen2_mode=0 -> 50 words, no bubble after the first word, order preserved.
REQ-033 LPIF_PACK_FLUSH_EN defined, FLUSH_CYCLES=4, single beat then idle -> out_valid=1 on the 6th cycle after acceptance, upper slot zero. Without the macro, out_valid stays 0 for 100 cycles.
REQ-034 rst_n dropped while in HALF -> pack_busy=0 and out_data=0 immediately. After release, one beat leaves the block in HALF and out_valid stays 0.
